// File: rtl/bin_sched_if.sv
// bin_sched_if: host, info-read, loader, core and writeback handshakes of the bin sequencer.
// master is the sequencer side, slave is the environment side.
interface bin_sched_if #(
    parameter int WIDTH_CLAUSES = 16,
    parameter int WIDTH_VARS    = 12,
    parameter int WIDTH_STAT    = 16
);
    logic                     start_i;
    logic                     busy_o;
    logic                     done_o;
    logic                     sat_o;
    logic                     unsat_o;
    logic                     start_rdinfo_o;
    logic                     done_rdinfo_i;
    logic [WIDTH_VARS-1:0]    nv_all_i;
    logic [WIDTH_CLAUSES-1:0] n_cbin_i;
    logic [WIDTH_VARS-1:0]    nv_all_o;
    logic [WIDTH_CLAUSES-1:0] n_cbin_o;
    logic [WIDTH_CLAUSES-1:0] cur_bin_o;
    logic                     start_load_o;
    logic                     load_done_i;
    logic                     start_core_o;
    logic                     core_done_i;
    logic                     core_sat_i;
    logic                     start_wb_o;
    logic                     wb_done_i;
    logic [WIDTH_STAT-1:0]    load_cnt_o;

    modport master (
        input  start_i, done_rdinfo_i, nv_all_i, n_cbin_i, load_done_i, core_done_i, core_sat_i, wb_done_i,
        output busy_o, done_o, sat_o, unsat_o, start_rdinfo_o, nv_all_o, n_cbin_o, cur_bin_o,
               start_load_o, start_core_o, start_wb_o, load_cnt_o
    );
    modport slave (
        output start_i, done_rdinfo_i, nv_all_i, n_cbin_i, load_done_i, core_done_i, core_sat_i, wb_done_i,
        input  busy_o, done_o, sat_o, unsat_o, start_rdinfo_o, nv_all_o, n_cbin_o, cur_bin_o,
               start_load_o, start_core_o, start_wb_o, load_cnt_o
    );
endinterface

// File: rtl/bin_sched_ctrl.sv
// bin_sched_ctrl: walks bins load -> core -> writeback with backtracking, reports global SAT/UNSAT.
// Define BIN_STAT_EN to enable the saturating bin-load counter on load_cnt_o.
module bin_sched_ctrl (
    input logic         clk,
    input logic         rst,
    bin_sched_if.master bus
);
    localparam int wc = $bits(bus.cur_bin_o);
    typedef enum logic [3:0] {
        IDLE, INFO, WAIT_INFO, LOAD, WAIT_LOAD, CORE, WAIT_CORE, WB, WAIT_WB, FINISH
    } state_t;
    state_t state;
    logic [wc-1:0] nxt_bin;
    assign nxt_bin = bus.cur_bin_o + wc'(1);
    // Request pulses are set on entry to their state and cleared by the default the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            bus.busy_o         <= 1'b0;
            bus.done_o         <= 1'b0;
            bus.sat_o          <= 1'b0;
            bus.unsat_o        <= 1'b0;
            bus.start_rdinfo_o <= 1'b0;
            bus.start_load_o   <= 1'b0;
            bus.start_core_o   <= 1'b0;
            bus.start_wb_o     <= 1'b0;
            bus.nv_all_o       <= '0;
            bus.n_cbin_o       <= '0;
            bus.cur_bin_o      <= '0;
        end else begin
            bus.start_rdinfo_o <= 1'b0;
            bus.start_load_o   <= 1'b0;
            bus.start_core_o   <= 1'b0;
            bus.start_wb_o     <= 1'b0;
            bus.done_o         <= 1'b0;
            case (state)
                IDLE: if (bus.start_i) begin
                    bus.sat_o          <= 1'b0;
                    bus.unsat_o        <= 1'b0;
                    bus.cur_bin_o      <= '0;
                    bus.busy_o         <= 1'b1;
                    bus.start_rdinfo_o <= 1'b1;
                    state              <= INFO;
                end
                INFO: state <= WAIT_INFO;
                WAIT_INFO: if (bus.done_rdinfo_i) begin
                    bus.nv_all_o <= bus.nv_all_i;
                    bus.n_cbin_o <= bus.n_cbin_i;
                    if (bus.n_cbin_i == '0) begin
                        bus.sat_o  <= 1'b1;
                        bus.done_o <= 1'b1;
                        state      <= FINISH;
                    end else begin
                        bus.start_load_o <= 1'b1;
                        state            <= LOAD;
                    end
                end
                LOAD: state <= WAIT_LOAD;
                WAIT_LOAD: if (bus.load_done_i) begin
                    bus.start_core_o <= 1'b1;
                    state            <= CORE;
                end
                CORE: state <= WAIT_CORE;
                WAIT_CORE: if (bus.core_done_i) begin
                    if (bus.core_sat_i) begin
                        bus.start_wb_o <= 1'b1;
                        state          <= WB;
                    end else if (bus.cur_bin_o == '0) begin
                        bus.unsat_o <= 1'b1;
                        bus.done_o  <= 1'b1;
                        state       <= FINISH;
                    end else begin
                        bus.cur_bin_o    <= bus.cur_bin_o - wc'(1);
                        bus.start_load_o <= 1'b1;
                        state            <= LOAD;
                    end
                end
                WB: state <= WAIT_WB;
                WAIT_WB: if (bus.wb_done_i) begin
                    bus.cur_bin_o <= nxt_bin;
                    if (nxt_bin == bus.n_cbin_o) begin
                        bus.sat_o  <= 1'b1;
                        bus.done_o <= 1'b1;
                        state      <= FINISH;
                    end else begin
                        bus.start_load_o <= 1'b1;
                        state            <= LOAD;
                    end
                end
                FINISH: begin
                    bus.busy_o <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef BIN_STAT_EN
    localparam int ws = $bits(bus.load_cnt_o);
    logic [ws-1:0] load_cnt;
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && bus.start_i)) load_cnt <= '0;
        else if (bus.start_load_o && !(&load_cnt)) load_cnt <= load_cnt + ws'(1);
    end
    assign bus.load_cnt_o = load_cnt;
`else
    assign bus.load_cnt_o = '0;
`endif
endmodule

// File: tb/tb_bin_sched_ctrl.sv
// tb_bin_sched_ctrl: table-driven and randomized solves checked against a bin-walk reference model.
module tb_bin_sched_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bin_sched_if #(.WIDTH_CLAUSES(16), .WIDTH_VARS(12), .WIDTH_STAT(16)) bus ();
    bin_sched_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    typedef struct {
        int       n;
        int       nv;
        bit [7:0] res;
        int       nres;
        bit       hold;
        bit       spur;
        bit       exp_sat;
        int       exp_loads;
        int       exp_cur;
    } vec_t;
    vec_t tbl[6];

    bit res_q[$];
    int exp_trace[$];
    int obs_trace[$];
    int exp_wb;
    int exp_cur;
    bit exp_sat;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: abstract depth-first walk over bin indices driven by the core result list.
    function automatic void model(input int n, input bit gen);
        int idx = 0;
        int k = 0;
        bit r;
        exp_trace.delete();
        exp_wb = 0;
        exp_sat = 1'b1;
        while (idx < n) begin
            exp_trace.push_back(idx);
            if (k >= res_q.size()) res_q.push_back(gen ? (k >= 30 || $urandom_range(0, 3) != 0) : 1'b1);
            r = res_q[k];
            k++;
            if (r) begin
                exp_wb++;
                idx++;
            end else if (idx == 0) begin
                exp_sat = 1'b0;
                break;
            end else idx--;
        end
        exp_cur = exp_sat ? n : 0;
    endfunction

    logic [3:0] prev_p = '0;
    always @(negedge clk) begin
        automatic logic [3:0] p = {bus.start_rdinfo_o, bus.start_load_o, bus.start_core_o, bus.start_wb_o};
        if (p != '0) begin
            tests++;
            if ((p & prev_p) != '0 || $countones(p) > 1) begin
                fails++;
                $display("FAIL pulse_shape: got %b after %b required single one-cycle pulse", p, prev_p);
            end
        end
        prev_p = p;
    end

    task automatic clear_inputs();
        bus.done_rdinfo_i = 1'b0;
        bus.load_done_i   = 1'b0;
        bus.core_done_i   = 1'b0;
        bus.core_sat_i    = 1'b0;
        bus.wb_done_i     = 1'b0;
        bus.nv_all_i      = 12'($urandom);
        bus.n_cbin_i      = 16'($urandom);
    endtask

    task automatic run_solve(input int n, input int nv, input bit hold, input bit spur,
                             input int abort_bin, output bit aborted);
        int pend = 0;
        int cnt = 0;
        int k = 0;
        int wbn = 0;
        bit csat = 1'b0;
        bit got_done = 1'b0;
        aborted = 1'b0;
        obs_trace.delete();
        @(negedge clk);
        bus.start_i = 1'b1;
        for (int cyc = 0; cyc < 3000 && !got_done && !aborted; cyc++) begin
            @(negedge clk);
            if (!hold) bus.start_i = 1'b0;
            clear_inputs();
            if (pend != 0) begin
                if (cnt == 0) begin
                    case (pend)
                        1: begin bus.done_rdinfo_i = 1'b1; bus.nv_all_i = 12'(nv); bus.n_cbin_i = 16'(n); end
                        2: bus.load_done_i = 1'b1;
                        3: begin bus.core_done_i = 1'b1; bus.core_sat_i = csat; end
                        default: bus.wb_done_i = 1'b1;
                    endcase
                    pend = 0;
                end else begin
                    cnt--;
                    if (spur && pend == 2) begin
                        bus.wb_done_i   = 1'b1;
                        bus.core_done_i = 1'b1;
                    end
                end
            end
            if (bus.start_rdinfo_o || bus.start_load_o || bus.start_core_o || bus.start_wb_o)
                chk("one_outstanding", pend, 0);
            if (bus.start_rdinfo_o) begin pend = 1; cnt = $urandom_range(0, 3); end
            if (bus.start_load_o) begin
                obs_trace.push_back(int'(bus.cur_bin_o));
                pend = 2;
                cnt = spur ? $urandom_range(1, 3) : $urandom_range(0, 3);
            end
            if (bus.start_core_o) begin
                if (int'(bus.cur_bin_o) == abort_bin) aborted = 1'b1;
                csat = (k < res_q.size()) ? res_q[k] : 1'b1;
                k++;
                pend = 3;
                cnt = $urandom_range(0, 3);
            end
            if (bus.start_wb_o) begin wbn++; pend = 4; cnt = $urandom_range(0, 3); end
            if (bus.done_o) got_done = 1'b1;
        end
        if (aborted) return;
        chk("done_seen", got_done, 1);
        chk("sat_o", bus.sat_o, exp_sat);
        chk("unsat_o", bus.unsat_o, !exp_sat);
        chk("busy_at_done", bus.busy_o, 1);
        chk("cur_bin_end", bus.cur_bin_o, exp_cur);
        chk("nv_all_o", bus.nv_all_o, nv);
        chk("n_cbin_o", bus.n_cbin_o, n);
        chk("wb_count", wbn, exp_wb);
        chk("trace_len", obs_trace.size(), exp_trace.size());
        for (int i = 0; i < obs_trace.size() && i < exp_trace.size(); i++)
            chk($sformatf("trace[%0d]", i), obs_trace[i], exp_trace[i]);
`ifdef BIN_STAT_EN
        chk("load_cnt_o", bus.load_cnt_o, exp_trace.size());
`else
        chk("load_cnt_o", bus.load_cnt_o, 0);
`endif
        bus.start_i = 1'b0;
        clear_inputs();
        @(negedge clk);
        chk("done_width", bus.done_o, 0);
        chk("busy_idle", bus.busy_o, 0);
        chk("sat_held", bus.sat_o, exp_sat);
    endtask

    initial begin
        bit ab;
        bit act;
        tbl[0] = '{n: 0, nv: 5,   res: 8'b0,    nres: 0, hold: 0, spur: 0, exp_sat: 1, exp_loads: 0, exp_cur: 0};
        tbl[1] = '{n: 3, nv: 100, res: 8'b111,  nres: 3, hold: 1, spur: 1, exp_sat: 1, exp_loads: 3, exp_cur: 3};
        tbl[2] = '{n: 2, nv: 7,   res: 8'b1101, nres: 4, hold: 0, spur: 0, exp_sat: 1, exp_loads: 4, exp_cur: 2};
        tbl[3] = '{n: 4, nv: 9,   res: 8'b0,    nres: 1, hold: 0, spur: 0, exp_sat: 0, exp_loads: 1, exp_cur: 0};
        tbl[4] = '{n: 1, nv: 33,  res: 8'b0,    nres: 1, hold: 1, spur: 0, exp_sat: 0, exp_loads: 1, exp_cur: 0};
        tbl[5] = '{n: 2, nv: 4095, res: 8'b001, nres: 3, hold: 0, spur: 1, exp_sat: 0, exp_loads: 3, exp_cur: 0};
        bus.start_i = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_sat", bus.sat_o, 0);
        chk("rst_unsat", bus.unsat_o, 0);
        chk("rst_nv_all", bus.nv_all_o, 0);
        chk("rst_n_cbin", bus.n_cbin_o, 0);
        chk("rst_cur_bin", bus.cur_bin_o, 0);
        chk("rst_load_cnt", bus.load_cnt_o, 0);
        rst = 1'b0;

        foreach (tbl[t]) begin
            res_q.delete();
            for (int i = 0; i < tbl[t].nres; i++) res_q.push_back(tbl[t].res[i]);
            model(tbl[t].n, 1'b0);
            run_solve(tbl[t].n, tbl[t].nv, tbl[t].hold, tbl[t].spur, -1, ab);
            chk($sformatf("tbl%0d_sat", t), bus.sat_o, tbl[t].exp_sat);
            chk($sformatf("tbl%0d_loads", t), obs_trace.size(), tbl[t].exp_loads);
            chk($sformatf("tbl%0d_cur", t), bus.cur_bin_o, tbl[t].exp_cur);
        end

        // Reset while waiting on the core for bin 2; the late core_done must be ignored.
        res_q.delete();
        model(3, 1'b0);
        run_solve(3, 11, 1'b0, 1'b0, 2, ab);
        chk("abort_reached", ab, 1);
        @(negedge clk);
        chk("abort_cur_bin", bus.cur_bin_o, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", bus.busy_o, 0);
        chk("midrst_cur_bin", bus.cur_bin_o, 0);
        chk("midrst_n_cbin", bus.n_cbin_o, 0);
        chk("midrst_nv_all", bus.nv_all_o, 0);
        chk("midrst_load_cnt", bus.load_cnt_o, 0);
        bus.core_done_i = 1'b1;
        bus.core_sat_i  = 1'b1;
        @(negedge clk);
        clear_inputs();
        act = 1'b0;
        repeat (6) begin
            @(negedge clk);
            act |= bus.busy_o | bus.done_o | bus.start_rdinfo_o | bus.start_load_o | bus.start_core_o | bus.start_wb_o;
        end
        chk("late_core_done_ignored", act, 0);

        for (int r = 0; r < 25; r++) begin
            automatic int n = $urandom_range(1, 5);
            res_q.delete();
            model(n, 1'b1);
            run_solve(n, $urandom_range(0, 4095), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, ab);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
